// File: rtl/uart_tx_frame_if.sv
// Host write port of the UART transmit framer: one parallel word plus its
// parity controls, transferred when data_valid & data_ready.
interface uart_tx_frame_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] p_data;
  logic              data_valid;
  logic              data_ready;
  logic              par_en;
  logic              par_typ;

  // Host side drives the word, the framer answers with data_ready.
  modport master (
    output p_data,
    output data_valid,
    output par_en,
    output par_typ,
    input  data_ready
  );

  modport slave (
    input  p_data,
    input  data_valid,
    input  par_en,
    input  par_typ,
    output data_ready
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity, stop bit(s).
// Each bit is held for PRESCALE clocks. tx_out and busy are registered.
// Optional feature macro: UART_TX_HOLD_BUF_EN adds a one-entry holding register
// so a word can be queued while a frame is in flight and frames run back to back.
module uart_tx_frame #(
  parameter int DATA_W    = 8,
  parameter int PRESCALE  = 8,
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_frame_if.slave  bus,
  output logic            tx_out,
  output logic            busy
);

  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(PRESCALE - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            r_state;
  logic [PS_W-1:0]   r_prescale;
  logic [BIT_W-1:0]  r_bit_idx;
  logic [DATA_W-1:0] r_data;
  logic              r_par_en;
  logic              r_par_bit;
  logic              r_tx_out;
  logic              r_busy;

  state_t            w_state_next;
  logic [PS_W-1:0]   w_prescale_next;
  logic [BIT_W-1:0]  w_bit_next;
  logic [DATA_W-1:0] w_data_next;
  logic              w_par_en_next;
  logic              w_par_bit_next;
  logic              w_tx_next;
  logic              w_accept;
  logic              w_par_in;
  logic              w_last_tick;
  logic              w_load_in;

`ifdef UART_TX_HOLD_BUF_EN
  logic              r_hold_full;
  logic [DATA_W-1:0] r_hold_data;
  logic              r_hold_par_en;
  logic              r_hold_par_bit;
  logic              w_load_hold;
  logic              w_store;

  assign bus.data_ready = ~r_hold_full;
`else
  assign bus.data_ready = ~r_busy & (r_state == S_IDLE);
`endif

  assign w_accept    = bus.data_valid & bus.data_ready;
  // Parity is fixed at acceptance so later input changes cannot leak into the frame.
  assign w_par_in    = bus.par_typ ? ~^bus.p_data : ^bus.p_data;
  assign w_last_tick = (r_prescale == PS_LAST);
  assign tx_out      = r_tx_out;
  assign busy        = r_busy;

  // Next-state, counters and the next line level (registered below, so no comb path to the pad).
  always_comb begin
    w_state_next    = r_state;
    w_prescale_next = w_last_tick ? '0 : r_prescale + 1'b1;
    w_bit_next      = r_bit_idx;
    w_data_next     = r_data;
    w_par_en_next   = r_par_en;
    w_par_bit_next  = r_par_bit;
    w_load_in       = 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
    w_load_hold     = 1'b0;
`endif
    w_tx_next       = 1'b1;

    case (r_state)
      S_IDLE: begin
        w_prescale_next = '0;
        if (w_accept) w_load_in = 1'b1;
      end
      S_START: begin
        if (w_last_tick) begin
          w_state_next = S_DATA;
          w_bit_next   = '0;
        end
      end
      S_DATA: begin
        if (w_last_tick) begin
          if (r_bit_idx == DATA_LAST) begin
            w_bit_next   = '0;
            w_state_next = r_par_en ? S_PARITY : S_STOP;
          end else begin
            w_bit_next = r_bit_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_last_tick) begin
          w_state_next = S_STOP;
          w_bit_next   = '0;
        end
      end
      S_STOP: begin
        if (w_last_tick) begin
          if (r_bit_idx == STOP_LAST) begin
            w_bit_next   = '0;
            w_state_next = S_IDLE;
`ifdef UART_TX_HOLD_BUF_EN
            // Chain straight into the next start bit when a word is waiting.
            if (r_hold_full) w_load_hold = 1'b1;
            else if (w_accept) w_load_in = 1'b1;
`endif
          end else begin
            w_bit_next = r_bit_idx + 1'b1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_load_in) begin
      w_state_next    = S_START;
      w_prescale_next = '0;
      w_bit_next      = '0;
      w_data_next     = bus.p_data;
      w_par_en_next   = bus.par_en;
      w_par_bit_next  = w_par_in;
    end
`ifdef UART_TX_HOLD_BUF_EN
    if (w_load_hold) begin
      w_state_next    = S_START;
      w_prescale_next = '0;
      w_bit_next      = '0;
      w_data_next     = r_hold_data;
      w_par_en_next   = r_hold_par_en;
      w_par_bit_next  = r_hold_par_bit;
    end
`endif

    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_data_next[w_bit_next];
      S_PARITY: w_tx_next = w_par_bit_next;
      default:  w_tx_next = 1'b1;
    endcase
  end

  // State, counters, latched frame word and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_prescale <= '0;
      r_bit_idx  <= '0;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_tx_out   <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_prescale <= w_prescale_next;
      r_bit_idx  <= w_bit_next;
      r_data     <= w_data_next;
      r_par_en   <= w_par_en_next;
      r_par_bit  <= w_par_bit_next;
      r_tx_out   <= w_tx_next;
      r_busy     <= (w_state_next != S_IDLE);
    end
  end

`ifdef UART_TX_HOLD_BUF_EN
  // A word accepted but not started directly is parked; a drain and a new store on
  // the same edge leave the buffer full with the new word.
  assign w_store = w_accept & ~w_load_in;

  // Holding register for the next queued word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_full    <= 1'b0;
      r_hold_data    <= '0;
      r_hold_par_en  <= 1'b0;
      r_hold_par_bit <= 1'b0;
    end else begin
      r_hold_full <= w_store | (r_hold_full & ~w_load_hold);
      if (w_store) begin
        r_hold_data    <= bus.p_data;
        r_hold_par_en  <= bus.par_en;
        r_hold_par_bit <= w_par_in;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed testbench for uart_tx_frame (DATA_W=8, PRESCALE=8).
// u_dut1 uses one stop bit, u_dut2 two stop bits. Back-to-back expectations
// follow UART_TX_HOLD_BUF_EN when the bench is built with it defined.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] tb_data;
  logic       tb_valid;
  logic       tb_pen;
  logic       tb_ptyp;
  logic       sel;
  logic       tx1, busy1, tx2, busy2;
  logic       tx_s, busy_s, ready_s;

  uart_tx_frame_if #(.DATA_W(8)) bus1 ();
  uart_tx_frame_if #(.DATA_W(8)) bus2 ();

  assign bus1.p_data     = tb_data;
  assign bus1.par_en     = tb_pen;
  assign bus1.par_typ    = tb_ptyp;
  assign bus1.data_valid = tb_valid & ~sel;
  assign bus2.p_data     = tb_data;
  assign bus2.par_en     = tb_pen;
  assign bus2.par_typ    = tb_ptyp;
  assign bus2.data_valid = tb_valid & sel;

  assign tx_s    = sel ? tx2 : tx1;
  assign busy_s  = sel ? busy2 : busy1;
  assign ready_s = sel ? bus2.data_ready : bus1.data_ready;

  uart_tx_frame #(.DATA_W(8), .PRESCALE(8), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .tx_out(tx1), .busy(busy1)
  );

  uart_tx_frame #(.DATA_W(8), .PRESCALE(8), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .tx_out(tx2), .busy(busy2)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  logic cap_line [0:255];
  int   cap_busy;
  int   exp_bits [0:15];

  // Record the selected line once per clock (on the falling edge) for n clocks.
  task automatic capture(input int n);
    cap_busy = 0;
    for (int i = 0; i < n; i++) begin
      cap_line[i] = tx_s;
      if (busy_s === 1'b1) cap_busy++;
      @(negedge clk);
    end
  endtask

  // Present one word at a falling edge; returns on the falling edge after acceptance.
  task automatic send(input logic [7:0] d, input logic pen, input logic ptyp);
    tb_data  = d;
    tb_pen   = pen;
    tb_ptyp  = ptyp;
    tb_valid = 1'b1;
    for (int t = 0; t < 300 && ready_s !== 1'b1; t++) @(negedge clk);
    n_cmp++;
    if (ready_s !== 1'b1) begin
      n_bad++;
      $display("FAIL send_ready: data_ready=%b required 1", ready_s);
    end
    @(negedge clk);
    tb_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; tb_valid = 1'b0; sel = 1'b0;
    tb_data = 8'h00; tb_pen = 1'b0; tb_ptyp = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 3;
    if (tx1 !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx1); end
    if (busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy1); end
    if (bus1.data_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus1.data_ready); end
    rst = 1'b0;
    @(negedge clk);
    send(8'h00, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (tx1 !== 1'b0 || busy1 !== 1'b1) begin
      n_bad++; $display("FAIL midframe_pre: tx=%b busy=%b want tx=0 busy=1", tx1, busy1);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp += 3;
    if (tx1 !== 1'b1) begin n_bad++; $display("FAIL abort_tx: got %b want 1", tx1); end
    if (busy1 !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy1); end
    if (bus1.data_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", bus1.data_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
      n_bad++; $display("FAIL abort_dropped: tx=%b busy=%b want tx=1 busy=0", tx1, busy1);
    end
    $display("tb: reset mid-frame, line idle tx=%b busy=%b", tx1, busy1);
  endtask

  task automatic test_no_parity;
    logic ok;
    sel = 1'b0;
    exp_bits = '{0,1,0,1,0,0,1,0,1,1,0,0,0,0,0,0};
    send(8'hA5, 1'b0, 1'b0);
    capture(90);
    for (int b = 0; b < 10; b++) begin
      ok = 1'b1;
      for (int j = 0; j < 8; j++) if (cap_line[b*8+j] !== 1'(exp_bits[b])) ok = 1'b0;
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL a5_bit%0d: got %b want %0d", b, cap_line[b*8+4], exp_bits[b]); end
    end
    n_cmp += 2;
    if (cap_busy != 80) begin n_bad++; $display("FAIL a5_busy_len: got %0d want 80", cap_busy); end
    if (cap_line[80] !== 1'b1) begin n_bad++; $display("FAIL a5_idle_after: got %b want 1", cap_line[80]); end
    $display("tb: sent 0xA5 no parity, busy %0d clks", cap_busy);
  endtask

  task automatic test_parity;
    logic       ok;
    logic [7:0] rx_d;
    logic       rx_err;
    sel = 1'b0;
    // Even parity on 0x07: three ones -> parity bit 1.
    exp_bits = '{0,1,1,1,0,0,0,0,0,1,1,0,0,0,0,0};
    send(8'h07, 1'b1, 1'b0);
    capture(96);
    for (int b = 0; b < 11; b++) begin
      ok = 1'b1;
      for (int j = 0; j < 8; j++) if (cap_line[b*8+j] !== 1'(exp_bits[b])) ok = 1'b0;
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL even07_bit%0d: got %b want %0d", b, cap_line[b*8+4], exp_bits[b]); end
    end
    for (int k = 0; k < 8; k++) rx_d[k] = cap_line[(1+k)*8+4];
    rx_err = ((^rx_d) ^ cap_line[9*8+4]) != 1'b0;
    n_cmp += 2;
    if (cap_busy != 88) begin n_bad++; $display("FAIL even07_busy_len: got %0d want 88", cap_busy); end
    if (rx_err !== 1'b0) begin n_bad++; $display("FAIL even07_rx_parity_err: got %b want 0", rx_err); end
    $display("tb: sent 0x07 even parity, parity bit %b, busy %0d clks", cap_line[9*8+4], cap_busy);

    // Odd parity on the same data -> parity bit 0.
    send(8'h07, 1'b1, 1'b1);
    capture(96);
    ok = 1'b1;
    for (int j = 0; j < 8; j++) if (cap_line[72+j] !== 1'b0) ok = 1'b0;
    for (int k = 0; k < 8; k++) rx_d[k] = cap_line[(1+k)*8+4];
    rx_err = ((^rx_d) ^ cap_line[9*8+4]) != 1'b1;
    n_cmp += 4;
    if (!ok) begin n_bad++; $display("FAIL odd07_parity_bit: got %b want 0", cap_line[76]); end
    if (rx_d !== 8'h07) begin n_bad++; $display("FAIL odd07_data: got %02h want 07", rx_d); end
    if (cap_busy != 88) begin n_bad++; $display("FAIL odd07_busy_len: got %0d want 88", cap_busy); end
    if (rx_err !== 1'b0) begin n_bad++; $display("FAIL odd07_rx_parity_err: got %b want 0", rx_err); end
    $display("tb: sent 0x07 odd parity, parity bit %b, busy %0d clks", cap_line[76], cap_busy);
  endtask

  task automatic test_stop2;
    logic ok_lo, ok_hi;
    sel = 1'b1;
    send(8'h00, 1'b1, 1'b0);
    capture(104);
    ok_lo = 1'b1;
    ok_hi = 1'b1;
    for (int i = 0; i < 80; i++) if (cap_line[i] !== 1'b0) ok_lo = 1'b0;
    for (int i = 80; i < 104; i++) if (cap_line[i] !== 1'b1) ok_hi = 1'b1 & 1'b0;
    n_cmp += 3;
    if (!ok_lo) begin n_bad++; $display("FAIL stop2_low_periods: start/data/parity not all 0 over 80 clks"); end
    if (!ok_hi) begin n_bad++; $display("FAIL stop2_stop_high: line not 1 after clk 80"); end
    if (cap_busy != 96) begin n_bad++; $display("FAIL stop2_busy_len: got %0d want 96", cap_busy); end
    $display("tb: sent 0x00 even parity two stop bits, busy %0d clks", cap_busy);
    sel = 1'b0;
  endtask

  task automatic test_hold_inputs;
    logic ok;
    sel = 1'b0;
    // 0x3C with odd parity: four ones -> parity bit 1.
    exp_bits = '{0,0,0,1,1,1,1,0,0,1,1,0,0,0,0,0};
    send(8'h3C, 1'b1, 1'b1);
    tb_data = 8'hFF;
    tb_ptyp = 1'b0;
    tb_pen  = 1'b0;
    capture(96);
    for (int b = 0; b < 11; b++) begin
      ok = 1'b1;
      for (int j = 0; j < 8; j++) if (cap_line[b*8+j] !== 1'(exp_bits[b])) ok = 1'b0;
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL latch3c_bit%0d: got %b want %0d", b, cap_line[b*8+4], exp_bits[b]); end
    end
    n_cmp++;
    if (cap_busy != 88) begin n_bad++; $display("FAIL latch3c_busy_len: got %0d want 88", cap_busy); end
    $display("tb: sent 0x3C odd parity with inputs changed mid-frame, busy %0d clks", cap_busy);
  endtask

  task automatic test_back_to_back;
    logic ok;
    int   s2;
    int   e1 [0:9];
    int   e2 [0:9];
`ifdef UART_TX_HOLD_BUF_EN
    s2 = 80;
`else
    s2 = 81;
`endif
    e1 = '{0,1,0,1,0,1,0,1,0,1};
    e2 = '{0,0,1,0,1,0,1,0,1,1};
    sel = 1'b0;
    tb_pen = 1'b0; tb_ptyp = 1'b0;
    send(8'h55, 1'b0, 1'b0);
    tb_valid = 1'b1;
    tb_data  = 8'hAA;
    cap_busy = 0;
    for (int i = 0; i < 180; i++) begin
      cap_line[i] = tx1;
      if (busy1 === 1'b1) cap_busy++;
`ifdef UART_TX_HOLD_BUF_EN
      if (i == 1) begin
        tb_data = 8'h33;
        n_cmp++;
        if (bus1.data_ready !== 1'b0) begin n_bad++; $display("FAIL hold_full_ready: got %b want 0", bus1.data_ready); end
      end
      if (i == 2) tb_valid = 1'b0;
`else
      if (i == 1) begin
        n_cmp++;
        if (bus1.data_ready !== 1'b0) begin n_bad++; $display("FAIL busy_ready: got %b want 0", bus1.data_ready); end
      end
      if (i == 81) tb_valid = 1'b0;
`endif
      @(negedge clk);
    end
    tb_valid = 1'b0;
    for (int b = 0; b < 10; b++) begin
      ok = 1'b1;
      for (int j = 0; j < 8; j++) if (cap_line[b*8+j] !== 1'(e1[b])) ok = 1'b0;
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL b2b_first_bit%0d: got %b want %0d", b, cap_line[b*8+4], e1[b]); end
    end
    for (int b = 0; b < 10; b++) begin
      ok = 1'b1;
      for (int j = 0; j < 8; j++) if (cap_line[s2+b*8+j] !== 1'(e2[b])) ok = 1'b0;
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL b2b_second_bit%0d: got %b want %0d", b, cap_line[s2+b*8+4], e2[b]); end
    end
    n_cmp += 2;
    if (cap_busy != 160) begin n_bad++; $display("FAIL b2b_busy_len: got %0d want 160", cap_busy); end
    if (cap_line[s2+80] !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_after: got %b want 1", cap_line[s2+80]); end
`ifndef UART_TX_HOLD_BUF_EN
    n_cmp++;
    if (cap_line[80] !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_gap: got %b want 1", cap_line[80]); end
`endif
    $display("tb: sent 0x55 then 0xAA, second start at clk %0d, busy %0d clks", s2, cap_busy);
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_stop2();
    test_hold_inputs();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
